// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command parser: frame states, header byte,
// command opcodes and the sticky error codes reported on err_code.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CHK  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CHK  = 2'b01,
    ERR_CMD  = 2'b10,
    ERR_TMO  = 2'b11
  } err_t;

  localparam logic [7:0] HDR      = 8'hAA;
  localparam logic [7:0] CMD_FREQ = 8'h01;
  localparam logic [7:0] CMD_MOD  = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts while a frame is open, restarts on every byte,
// and flags expiry for one cycle unless a byte arrives in that same cycle.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 208333
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // A byte in the expiry cycle masks the timeout so the frame can advance.
  assign expire = run & ~clear & (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (clear | ~run | expire) r_cnt <= '0;
    else                           r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (AA CMD DHI DLO CHK) from the UART receiver
// and writes the SPWM frequency, modulation and run-enable registers.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 208333,
  parameter logic [15:0] FREQ_DEFAULT   = 16'd60,
  parameter logic [15:0] MOD_DEFAULT    = 16'd32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [15:0] freq_word,
  output logic [15:0] mod_index,
  output logic        run_en,
  output logic        cfg_update,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  state_t     r_state;
  logic       r_rx_done_q;
  logic [7:0] r_cmd;
  logic [7:0] r_dhi;
  logic [7:0] r_dlo;

  logic w_byte_stb;
  logic w_timer_run;
  logic w_expire;
  logic w_chk_ok;

  // rx_done_q resets high so a level already present at reset release is not a byte.
  assign w_byte_stb  = rx_done & ~r_rx_done_q;
  assign w_timer_run = (r_state != IDLE);
  assign w_chk_ok    = (rx_data == frame_chk(r_cmd, r_dhi, r_dlo));

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_byte_stb),
    .run   (w_timer_run),
    .expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_done_q <= 1'b1;
      r_cmd       <= '0;
      r_dhi       <= '0;
      r_dlo       <= '0;
      freq_word   <= FREQ_DEFAULT;
      mod_index   <= MOD_DEFAULT;
      run_en      <= 1'b0;
      cfg_update  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      r_rx_done_q <= rx_done;
      cfg_update  <= 1'b0;
      frame_err   <= 1'b0;
      if (w_byte_stb) begin
        unique case (r_state)
          IDLE: if (rx_data == HDR) r_state <= CMD;
          CMD: begin
            r_cmd   <= rx_data;
            r_state <= DHI;
          end
          DHI: begin
            r_dhi   <= rx_data;
            r_state <= DLO;
          end
          DLO: begin
            r_dlo   <= rx_data;
            r_state <= CHK;
          end
          CHK: begin
            r_state <= IDLE;
            if (!w_chk_ok) begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end else begin
              unique case (r_cmd)
                CMD_FREQ: begin
                  freq_word  <= {r_dhi, r_dlo};
                  cfg_update <= 1'b1;
                end
                CMD_MOD: begin
                  mod_index  <= {r_dhi, r_dlo};
                  cfg_update <= 1'b1;
                end
                CMD_RUN: begin
                  run_en     <= r_dlo[0];
                  cfg_update <= 1'b1;
                end
                default: begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CMD;
                end
              endcase
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_expire) begin
        r_state   <= IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
  end

endmodule
